tf_bank_arb: RTL

Arbiter and sequencer for the shared single-port twiddle-factor SRAM bank (256×DATA_W, low-active chip enable), sitting between the tf generator write path and the NTT read port. Generator writes are absorbed into a small write FIFO and drained into the bank in idle cycles. Reads normally win. Read-after-write hazards and write starvation are resolved inside the block, so neither client needs to know about the other.

---
 rtl/tf_bank_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/tf_bank_arb.sv
`default_nettype none
// ============================================================================
// tf_bank_arb : twiddle-factor SRAM bank arbiter (write FIFO + 2-cycle read)
// Rev 1.0
// ============================================================================
module tf_bank_arb #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_vld,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_rdy,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_gnt,
  output logic                          rd_vld,
  output logic [DATA_W-1:0]             rd_data,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_d,
  output logic                          mem_web,
  output logic                          mem_ceb,
  input  logic [DATA_W-1:0]             mem_q,
  output logic                          idle,
  output logic [$clog2(STARVE_MAX):0]   starve_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_MAX);

  logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              rd_p1_q, rd_vld_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic                  nonempty, push, do_wr, do_rd, hz;
  logic [FIFO_DEPTH-1:0] match;

  // Hazard compares only registered entries, so a same-cycle enqueue never matches
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hz
    logic [PTR_W-1:0] ofs;
    assign ofs       = PTR_W'(gi) - head_q;
    assign match[gi] = ({1'b0, ofs} < count_q) && (fa_q[gi] == rd_addr);
  end

  assign nonempty = (count_q != '0);
  assign wr_rdy   = (count_q != DEPTH_C);
  assign push     = rst_n & wr_vld & wr_rdy;
  assign hz       = rd_req & (|match);
  // Forced/hazard writes beat reads; otherwise writes only fill idle slots
  assign do_wr    = rst_n & nonempty & ((starve_q == STARVE_C) | hz | ~rd_req);
  assign do_rd    = rst_n & rd_req & ~do_wr;

  assign rd_gnt   = do_rd;
  assign mem_ceb  = ~(do_wr | do_rd);
  assign mem_web  = ~do_wr;
  assign mem_addr = do_wr ? fa_q[head_q] : (do_rd ? rd_addr : '0);
  assign mem_d    = do_wr ? fd_q[head_q] : '0;

  assign rd_vld     = rd_vld_q;
  assign rd_data    = rd_data_q;
  assign idle       = ~nonempty & ~rd_p1_q & ~rd_vld_q;
  assign starve_cnt = starve_q;

  always_comb begin
    head_d    = do_wr ? head_q + 1'b1 : head_q;
    tail_d    = push ? tail_q + 1'b1 : tail_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(do_wr);
    rd_data_d = rd_p1_q ? mem_q : rd_data_q;
    starve_d  = starve_q;
    if (!nonempty || do_wr) begin
      starve_d = '0;
    end else if (do_rd && (starve_q != STARVE_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      rd_p1_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rd_p1_q   <= do_rd;
      rd_vld_q  <= rd_p1_q;
      rd_data_q <= rd_data_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by head/count
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[tail_q] <= wr_addr;
      fd_q[tail_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire
